imem_access_arbiter: RTL

//   Shares the single-ported 32-entry instruction memory between the processor fetch port (read)
//   and the program-load port (write). Sequences boot: memory is loaded first, then the CPU runs.

---
 rtl/imem_access_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-ported instruction memory between the CPU fetch port and
// the program loader, sequencing BOOT (load only) then RUN (fetch priority with loader starvation guard).
module imem_access_arbiter #(
  parameter int DEPTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        ip_clk,
  input  logic        ip_rst_n,
  input  logic        ip_fetch_req,
  input  logic [31:0] ip_fetch_addr,
  output logic        op_fetch_gnt,
  output logic        op_fetch_valid,
  output logic [31:0] op_fetch_instr,
  output logic        op_fetch_err,
  input  logic        ip_load_req,
  input  logic [31:0] ip_load_addr,
  input  logic [31:0] ip_load_data,
  output logic        op_load_gnt,
  output logic        op_load_err,
  input  logic        ip_boot_done,
  input  logic        ip_reload,
  output logic        op_cpu_run,
  output logic [31:0] op_mem_addr,
  output logic [31:0] op_mem_wdata,
  output logic        op_mem_we,
  input  logic [31:0] ip_mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          fetch_err_q, fetch_err_d;
  logic [31:0]   fetch_instr_q, fetch_instr_d;
  logic          load_err_q, load_err_d;

  logic fetch_gnt, load_gnt, fetch_legal, load_legal, starve_full;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
  endfunction

  assign fetch_legal = addr_legal(ip_fetch_addr);
  assign load_legal  = addr_legal(ip_load_addr);
  assign starve_full = (starve_q == CW'(STARVE_MAX));

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (state_q == BOOT) begin
      load_gnt = ip_load_req;
    end else begin
      // Fetch wins a tie unless the loader has waited STARVE_MAX cycles.
      if (ip_load_req && (!ip_fetch_req || starve_full)) begin
        load_gnt = 1'b1;
      end else begin
        fetch_gnt = ip_fetch_req;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    fetch_valid_d = fetch_gnt;
    fetch_err_d   = fetch_gnt && !fetch_legal;
    fetch_instr_d = (fetch_gnt && fetch_legal) ? ip_mem_rdata : 32'h0;
    load_err_d    = load_gnt && !load_legal;

    case (state_q)
      BOOT: begin
        starve_d = '0;
        if (ip_boot_done) state_d = RUN;
      end
      RUN: begin
        if (!ip_load_req || load_gnt) begin
          starve_d = '0;
        end else if (!starve_full) begin
          starve_d = starve_q + 1'b1;
        end
        if (ip_reload) begin
          state_d  = BOOT;
          starve_d = '0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (!ip_rst_n) begin
      state_q       <= BOOT;
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_instr_q <= 32'h0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_instr_q <= fetch_instr_d;
      load_err_q    <= load_err_d;
    end
  end

  assign op_fetch_gnt   = fetch_gnt;
  assign op_load_gnt    = load_gnt;
  assign op_fetch_valid = fetch_valid_q;
  assign op_fetch_err   = fetch_err_q;
  assign op_fetch_instr = fetch_instr_q;
  assign op_load_err    = load_err_q;
  assign op_cpu_run     = (state_q == RUN);
  assign op_mem_addr    = load_gnt ? ip_load_addr : ip_fetch_addr;
  assign op_mem_wdata   = ip_load_data;
  assign op_mem_we      = load_gnt && load_legal;

endmodule
